// File: rtl/dvs_aer_rx_param.sv
// DVS camera AER receiver: synchronizes the asynchronous AER bus, runs the 4-phase
// REQ/ACK handshake and queues timestamped {x, y, ts, pol} events in a show-ahead FIFO.
module dvs_aer_rx_param #(
  parameter int AER_BITS     = 10,
  parameter int X_BITS       = 9,
  parameter int Y_BITS       = 8,
  parameter int TS_BITS      = 32,
  parameter int TS_DIV       = 10,
  parameter int SETUP_CYCLES = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AER_BITS-1:0]           aer,
  input  logic                          xsel,
  input  logic                          req,
  output logic                          ack,
  input  logic                          cfg_drop_on_full,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [X_BITS-1:0]             ev_x,
  output logic [Y_BITS-1:0]             ev_y,
  output logic [TS_BITS-1:0]            ev_ts,
  output logic                          ev_pol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int SW    = AER_BITS + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PS_W  = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int CNT_W = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
  localparam int EV_W  = X_BITS + Y_BITS + TS_BITS + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACK} state_t;

  // Handshake: the camera holds aer/xsel stable from req rise until it sees ack;
  // ack stays high until the synced req falls. Consumer side: pop on ev_valid & ev_ready.

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic                           req_s, xsel_s;
  logic [AER_BITS-1:0]            aer_s;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic [TS_BITS-1:0]   us_q, us_d;
  logic [Y_BITS-1:0]    y_q, y_d;
  logic [TS_BITS-1:0]   ts_q, ts_d;
  logic [15:0]          drop_q, drop_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [EV_W-1:0]      mem_q [FIFO_DEPTH];
  logic [EV_W-1:0]      push_data, head;
  logic                 push, pop, full;

  // req, xsel and aer share one chain so they emerge on the same cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {req, xsel, aer}};
  end
  assign {req_s, xsel_s, aer_s} = sync_q[SYNC_STAGES-1];

  always_comb begin
    ps_d = ps_q + PS_W'(1);
    us_d = us_q;
    if (ps_q == PS_W'(TS_DIV - 1)) begin
      ps_d = '0;
      us_d = us_q + TS_BITS'(1);
    end
  end

  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign push_data = {aer_s[X_BITS:1], y_q, ts_q, aer_s[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ts_d    = ts_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES);
        end
      end
      SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!xsel_s) begin
          y_d     = aer_s[Y_BITS-1:0];
          ts_d    = us_q;
          state_d = ACK;
        end else if (!full) begin
          push    = 1'b1;
          state_d = ACK;
        end else if (cfg_drop_on_full) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = ACK;
        end
        // Full in stall mode: hold here with ack low until space appears.
      end
      ACK: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ev_valid = (level_q != '0);
  assign pop      = ev_valid & ev_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      ps_q     <= '0;
      us_q     <= '0;
      y_q      <= '0;
      ts_q     <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      us_q     <= us_d;
      y_q      <= y_d;
      ts_q     <= ts_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Outputs read zero whenever the FIFO is empty, so stale entries never leak out.
  always_comb begin
    head = ev_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign {ev_x, ev_y, ev_ts, ev_pol} = head;
  assign ack        = (state_q == ACK);
  assign fifo_level = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dvs_aer_rx_param.sv
// Bench for dvs_aer_rx_param: default instance for capture/FIFO behaviour and a
// fast instance (no setup wait, 3-stage sync, 4-bit timestamps at 1 cycle/us).
module tb_dvs_aer_rx_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  aer = '0;
  logic        xsel = 1'b0, req = 1'b0, cfg_drop_on_full = 1'b1, ev_ready = 1'b0;
  logic        ack, ev_valid, ev_pol;
  logic [8:0]  ev_x;
  logic [7:0]  ev_y;
  logic [31:0] ev_ts;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  logic [9:0]  aer2 = '0;
  logic        xsel2 = 1'b0, req2 = 1'b0, ev_ready2 = 1'b0;
  logic        ack2, ev_valid2, ev_pol2;
  logic [8:0]  ev_x2;
  logic [7:0]  ev_y2;
  logic [3:0]  ev_ts2;
  logic [3:0]  fifo_level2;
  logic [15:0] drop_count2;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [49:0] exp_q[$];
  logic [7:0]  y_m = '0;
  logic [31:0] ts_m = '0;
  int          lvl_m = 0;
  int          drop_m = 0;

  dvs_aer_rx_param dut (
    .clk(clk), .rst(rst), .aer(aer), .xsel(xsel), .req(req), .ack(ack),
    .cfg_drop_on_full(cfg_drop_on_full), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_ts(ev_ts), .ev_pol(ev_pol),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  dvs_aer_rx_param #(.TS_BITS(4), .TS_DIV(1), .SETUP_CYCLES(0), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst(rst), .aer(aer2), .xsel(xsel2), .req(req2), .ack(ack2),
    .cfg_drop_on_full(1'b1), .ev_valid(ev_valid2), .ev_ready(ev_ready2),
    .ev_x(ev_x2), .ev_y(ev_y2), .ev_ts(ev_ts2), .ev_pol(ev_pol2),
    .fifo_level(fifo_level2), .drop_count(drop_count2)
  );

  // Clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic start_word(input logic xs, input logic [9:0] a);
    @(negedge clk);
    aer  = a;
    xsel = xs;
    req  = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output int lat, output int ok);
    lat = 0;
    ok  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        ok  = 1;
        break;
      end
    end
  endtask

  task automatic end_word();
    int ok;
    @(negedge clk);
    req = 1'b0;
    ok  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!ack) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL ack_release: ack=%b after req low, expected 0", ack);
    end
  endtask

  // Full handshake; the scoreboard model is updated at the cycle ack rises.
  task automatic do_word(input logic xs, input logic [9:0] a, output int lat);
    int ok;
    start_word(xs, a);
    wait_ack(100, lat, ok);
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL handshake: ack=0 after 100 cycles, expected 1 (xsel=%b aer=%h)", xs, a);
    end else if (!xs) begin
      y_m  = a[7:0];
      ts_m = 32'((cyc - 1) / 10);
    end else if (lvl_m < 8) begin
      exp_q.push_back({a[9:1], y_m, ts_m, a[0]});
      lvl_m++;
    end else if (drop_m < 65535) begin
      drop_m++;
    end
    end_word();
  endtask

  task automatic pop_check();
    logic [49:0] e, got;
    @(negedge clk);
    got = {ev_x, ev_y, ev_ts, ev_pol};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pop_head: ev_valid=%b head=%h, expected an entry in the scoreboard", ev_valid, got);
    end else begin
      e = exp_q.pop_front();
      if (ev_valid !== 1'b1 || got !== e) begin
        errors++;
        $display("FAIL pop_head: ev_valid=%b head=%h, expected valid=1 head=%h", ev_valid, got, e);
      end
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
      lvl_m--;
      checks++;
      if (fifo_level !== 4'(lvl_m)) begin
        errors++;
        $display("FAIL pop_level: fifo_level=%0d, expected %0d", fifo_level, lvl_m);
      end
    end
  endtask

  task automatic d2_word(input logic xs, input logic [9:0] a, output int lat);
    int ok;
    @(negedge clk);
    aer2 = a; xsel2 = xs; req2 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (ack2) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL d2_handshake: ack2=0 after 50 cycles, expected 1");
    end
    @(negedge clk);
    req2 = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!ack2) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL d2_ack_release: ack2=%b, expected 0", ack2);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || ev_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ack=%b ev_valid=%b level=%0d drops=%0d, expected all 0",
               ack, ev_valid, fifo_level, drop_count);
    end
    checks++;
    if ({ev_x, ev_y, ev_ts, ev_pol} !== 50'd0 || ack2 !== 1'b0 || fifo_level2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_fields: head=%h ack2=%b level2=%0d, expected 0",
               {ev_x, ev_y, ev_ts, ev_pol}, ack2, fifo_level2);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ack=%b ev_valid=%b, expected 0 with req low", ack, ev_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_word(1'b1, 10'h1FE, lat);
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_y !== 8'd0 || ev_ts !== 32'd0) begin
      errors++;
      $display("FAIL x_before_y: valid=%b y=%h ts=%0d, expected valid=1 y=0 ts=0", ev_valid, ev_y, ev_ts);
    end
    pop_check();
    while (cyc != 995) @(negedge clk);
    do_word(1'b0, 10'h005, lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL y_latency: ack on edge %0d after drive, expected edge 7 (6 cycles after capture)", lat);
    end
    do_word(1'b1, 10'h0A3, lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL x_latency: ack on edge %0d after drive, expected edge 7", lat);
    end
    @(negedge clk);
    checks++;
    if (ev_x !== 9'h051 || ev_y !== 8'h05 || ev_ts !== 32'd100 || ev_pol !== 1'b1) begin
      errors++;
      $display("FAIL basic_event: x=%h y=%h ts=%0d pol=%b, expected x=051 y=05 ts=100 pol=1",
               ev_x, ev_y, ev_ts, ev_pol);
    end
    pop_check();
  endtask

  task automatic test_drop();
    int lat;
    cfg_drop_on_full = 1'b1;
    ev_ready = 1'b0;
    do_word(1'b0, 10'($urandom_range(0, 1023)), lat);
    for (int i = 0; i < 10; i++) do_word(1'b1, 10'($urandom_range(0, 1023)), lat);
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_full: level=%0d drops=%0d, expected level=8 drops=2", fifo_level, drop_count);
    end
    for (int i = 0; i < 8; i++) pop_check();
    @(negedge clk);
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    ev_ready = 1'b0;
    checks++;
    if (fifo_level !== 4'd0 || ev_valid !== 1'b0 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL empty_pop: level=%0d valid=%b drops=%0d, expected 0/0/2", fifo_level, ev_valid, drop_count);
    end
  endtask

  task automatic test_stall();
    int lat, ok, seen;
    logic [9:0] a;
    cfg_drop_on_full = 1'b0;
    do_word(1'b0, 10'($urandom_range(0, 1023)), lat);
    for (int i = 0; i < 8; i++) do_word(1'b1, 10'($urandom_range(0, 1023)), lat);
    a = 10'($urandom_range(0, 1023));
    start_word(1'b1, a);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1;
    end
    checks++;
    if (seen != 0 || fifo_level !== 4'd8) begin
      errors++;
      $display("FAIL stall_hold: ack_seen=%0d level=%0d, expected ack never 1 and level 8", seen, fifo_level);
    end
    pop_check();
    wait_ack(20, lat, ok);
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL stall_release: ack=0 after pop, expected 1");
    end else begin
      exp_q.push_back({a[9:1], y_m, ts_m, a[0]});
      lvl_m++;
    end
    end_word();
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_level: level=%0d drops=%0d, expected level=8 drops=2", fifo_level, drop_count);
    end
    for (int i = 0; i < 8; i++) pop_check();
  endtask

  task automatic test_fast_latency();
    int lat;
    d2_word(1'b0, 10'h011, lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL fast_latency: ack2 on edge %0d after drive, expected edge 5 (4 cycles after capture)", lat);
    end
  endtask

  task automatic test_ts_wrap();
    int lat;
    while ((cyc % 16) != 11) @(negedge clk);
    d2_word(1'b0, 10'h13C, lat);
    d2_word(1'b1, 10'h155, lat);
    @(negedge clk);
    checks++;
    if (ev_valid2 !== 1'b1 || ev_ts2 !== 4'd0 || ev_y2 !== 8'h3C || ev_x2 !== 9'h0AA || ev_pol2 !== 1'b1) begin
      errors++;
      $display("FAIL ts_wrap_zero: valid=%b ts=%0d y=%h x=%h pol=%b, expected 1/0/3C/0AA/1",
               ev_valid2, ev_ts2, ev_y2, ev_x2, ev_pol2);
    end
    ev_ready2 = 1'b1;
    @(negedge clk);
    ev_ready2 = 1'b0;
    while ((cyc % 16) != 10) @(negedge clk);
    d2_word(1'b0, 10'h0C3, lat);
    d2_word(1'b1, 10'h002, lat);
    @(negedge clk);
    checks++;
    if (ev_valid2 !== 1'b1 || ev_ts2 !== 4'd15 || ev_y2 !== 8'hC3 || ev_x2 !== 9'h001 || ev_pol2 !== 1'b0) begin
      errors++;
      $display("FAIL ts_wrap_max: valid=%b ts=%0d y=%h x=%h pol=%b, expected 1/15/C3/001/0",
               ev_valid2, ev_ts2, ev_y2, ev_x2, ev_pol2);
    end
    ev_ready2 = 1'b1;
    @(negedge clk);
    ev_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, ok;
    cfg_drop_on_full = 1'b1;
    do_word(1'b0, 10'($urandom_range(0, 1023)), lat);
    for (int i = 0; i < 3; i++) do_word(1'b1, 10'($urandom_range(0, 1023)), lat);
    start_word(1'b0, 10'h033);
    wait_ack(100, lat, ok);
    checks++;
    if (ok == 0 || fifo_level !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset: ack_ok=%0d level=%0d, expected ack and level 3", ok, fifo_level);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || ev_valid !== 1'b0 || fifo_level !== 4'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b valid=%b level=%0d drops=%0d, expected all 0",
               ack, ev_valid, fifo_level, drop_count);
    end
    req = 1'b0;
    exp_q.delete();
    lvl_m = 0; y_m = '0; ts_m = '0; drop_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ack=%b, expected 0", ack);
    end
    do_word(1'b0, 10'h2AA, lat);
    do_word(1'b1, 10'h1C7, lat);
    pop_check();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_stall();
    test_fast_latency();
    test_ts_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvs_aer_rx_param.md
DVS_AER_RX_PARAM -- requirements
Module: dvs_aer_rx_param

Interface
REQ-001 SHALL have parameters (name, default, meaning): AER_BITS 10 AER bus width; X_BITS 9 X address width, X_BITS+1 <= AER_BITS; Y_BITS 8 Y address width, Y_BITS <= AER_BITS; TS_BITS 32 timestamp width in us; TS_DIV 10 clock cycles per us, >= 1; SETUP_CYCLES 3 wait cycles after synced REQ before sampling AER; SYNC_STAGES 2 synchronizer depth, >= 2; FIFO_DEPTH 8 event FIFO entries, power of 2, >= 2.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 aer  in  AER_BITS  asynchronous AER data from camera.
REQ-006 xsel  in  1  asynchronous; 0 = Y address word, 1 = X address + polarity word.
REQ-007 req  in  1  asynchronous camera request.
REQ-008 ack  out  1  handshake acknowledge to camera.
REQ-009 cfg_drop_on_full  in  1  1 = drop X events when FIFO full; 0 = stall handshake until space; sampled only in SETUP.
REQ-010 ev_valid  out  1  FIFO head holds an event.
REQ-011 ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
REQ-012 ev_x / ev_y / ev_ts / ev_pol  out  X_BITS / Y_BITS / TS_BITS / 1  fields of FIFO head (show-ahead).
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 drop_count  out  16  saturating count of dropped X events.

Function
REQ-015 aer, xsel, req SHALL each pass through a SYNC_STAGES-deep flop chain; only synced copies drive logic.
REQ-016 Free-running prescaler SHALL count 0..TS_DIV-1; on wrap the us counter SHALL increment, wrapping 2^TS_BITS-1 -> 0.
REQ-017 FSM states: IDLE, SETUP, ACK; registered; ack = 1 exactly when state == ACK.
REQ-018 IDLE: synced req = 1 -> SETUP with delay counter loaded SETUP_CYCLES; else stay.
REQ-019 SETUP: counter != 0 -> decrement, stay; counter == 0 -> sample synced aer/xsel this cycle per REQ-020..022.
REQ-020 Y word (xsel 0): latch y_reg = aer[Y_BITS-1:0], ts_reg = us counter; -> ACK; no FIFO write.
REQ-021 X word, FIFO not full: push {x = aer[X_BITS:1], y_reg, ts_reg, pol = aer[0]}; -> ACK.
REQ-022 X word, FIFO full: cfg_drop_on_full = 1 -> no push, drop_count += 1 (saturate at 65535), -> ACK; cfg_drop_on_full = 0 -> stay SETUP (counter at 0), re-evaluate each cycle, ack held 0.
REQ-023 Full SHALL be the registered occupancy == FIFO_DEPTH; a pop in the same cycle does not free space for that cycle's push.
REQ-024 ACK: synced req = 0 -> IDLE; else stay.
REQ-025 Capture latency: SYNC_STAGES + 1 + SETUP_CYCLES cycles from req rising at input flop to ack = 1; ev_valid rises the cycle after the push.
REQ-026 Pop on ev_valid & ev_ready; ev_* SHALL hold stable while ev_valid & !ev_ready.
REQ-027 Simultaneous push and pop when not full: occupancy unchanged, both take effect.
REQ-028 X word before any Y word since reset SHALL use y_reg = 0, ts_reg = 0.
REQ-029 ev_ready while empty SHALL have no effect; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 On rst = 1, asynchronously: state IDLE, ack 0, synchronizers 0, prescaler and us counter 0, y_reg/ts_reg 0, FIFO empty, ev_valid 0, ev_* 0, fifo_level 0, drop_count 0.
REQ-031 Reset mid-handshake SHALL abort it; after release the block waits in IDLE for synced req = 1.

Verification
REQ-032 Defaults; Y=0x05 at us 100, then X word 0x0A3 -> ack after 6 cycles each; one event x=0x51, y=0x05, ts=100, pol=1.
REQ-033 SETUP_CYCLES=0, SYNC_STAGES=3 -> ack rises exactly 4 cycles after req rises at input.
REQ-034 ev_ready=0, drop mode, 10 X words -> fifo_level 8, drop_count 2, all 10 handshakes complete.
REQ-035 ev_ready=0, stall mode, 9th X word -> ack stays 0; one pop -> X pushed, ack rises, fifo_level 8.
REQ-036 TS_BITS=4, TS_DIV=1 -> us counter wraps 15 -> 0; Y captured at wrap records 0.
REQ-037 rst pulsed while ack=1 with 3 events queued -> ack 0, ev_valid 0, fifo_level 0 immediately; next Y/X pair handled normally.
